key_sequencer: RTL and testbench

Iterative controller for the PRESENT-80 key schedule. It loads an 80-bit cipher key and steps the existing combinational `key_schedule` round function once per accepted round key. It streams round keys K1..K_ROUNDS (64 bits each) to the cipher datapath over a valid/ready handshake. It sits between the key input and the round-key XOR stage of the iterative PRESENT core.

---
 rtl/key_sequencer.sv | 133 +++++++++++++
 tb/tb_key_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sequencer.sv
// PRESENT-80 round-key sequencer: loads an 80-bit key and streams
// round keys K1..K_ROUNDS over a valid/ready handshake.

module key_schedule (
    input  logic [79:0] x,
    input  logic [4:0]  i,
    output logic [79:0] r
);

    function automatic logic [3:0] sbox(input logic [3:0] v);
        logic [3:0] s;
        unique case (v)
            4'h0: s = 4'hc;
            4'h1: s = 4'h5;
            4'h2: s = 4'h6;
            4'h3: s = 4'hb;
            4'h4: s = 4'h9;
            4'h5: s = 4'h0;
            4'h6: s = 4'ha;
            4'h7: s = 4'hd;
            4'h8: s = 4'h3;
            4'h9: s = 4'he;
            4'ha: s = 4'hf;
            4'hb: s = 4'h8;
            4'hc: s = 4'h4;
            4'hd: s = 4'h7;
            4'he: s = 4'h1;
            default: s = 4'h2;
        endcase
        return s;
    endfunction

    logic [79:0] rot;

    always_comb begin
        rot          = {x[18:0], x[79:19]};
        r            = rot;
        r[79:76]     = sbox(rot[79:76]);
        r[19:15]     = rot[19:15] ^ i;
    end

endmodule

module key_sequencer #(
    parameter int ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key,
    output logic [63:0] rk,
    output logic [5:0]  rk_idx,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST = 6'(ROUNDS);

    state_t      state, state_nxt;
    logic [79:0] ks, ks_nxt, ks_r;
    logic [5:0]  rnd, rnd_nxt;

    // Counter passed in is the index of the key being replaced.
    key_schedule u_ks (
        .x (ks),
        .i (rnd[4:0]),
        .r (ks_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ks    <= '0;
            rnd   <= '0;
        end else begin
            state <= state_nxt;
            ks    <= ks_nxt;
            rnd   <= rnd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ks_nxt    = ks;
        rnd_nxt   = rnd;
        rk        = '0;
        rk_idx    = '0;
        rk_valid  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ks_nxt    = key;
                    rnd_nxt   = 6'd1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                rk_valid = 1'b1;
                rk       = ks[79:16];
                rk_idx   = rnd;
                busy     = 1'b1;
                if (rk_ready) begin
                    // Last key accepted: no further key is derived.
                    if (rnd == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        ks_nxt  = ks_r;
                        rnd_nxt = rnd + 6'd1;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer: vector table plus handshake,
// reset and short-run corner cases.

module tb_key_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [79:0] key;
    logic [63:0] rk;
    logic [5:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        busy;
    logic        done;

    logic        start2;
    logic [79:0] key2;
    logic [63:0] rk2;
    logic [5:0]  rk_idx2;
    logic        rk_valid2;
    logic        rk_ready2;
    logic        busy2;
    logic        done2;

    int nvec;
    int nerr;

    key_sequencer #(.ROUNDS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    key_sequencer #(.ROUNDS(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .key      (key2),
        .rk       (rk2),
        .rk_idx   (rk_idx2),
        .rk_valid (rk_valid2),
        .rk_ready (rk_ready2),
        .busy     (busy2),
        .done     (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [79:0] k;
        logic        rdy;
        logic        rs;
        logic [63:0] erk;
        logic [5:0]  eidx;
        logic        ev;
        logic        eb;
        logic        ed;
    } vec_t;

    vec_t vq[$];

    logic [63:0] mk0 [1:32];
    logic [63:0] mk1 [1:32];

    function automatic logic [3:0] sb(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'h0: s = 4'hc;  4'h1: s = 4'h5;  4'h2: s = 4'h6;  4'h3: s = 4'hb;
            4'h4: s = 4'h9;  4'h5: s = 4'h0;  4'h6: s = 4'ha;  4'h7: s = 4'hd;
            4'h8: s = 4'h3;  4'h9: s = 4'he;  4'ha: s = 4'hf;  4'hb: s = 4'h8;
            4'hc: s = 4'h4;  4'hd: s = 4'h7;  4'he: s = 4'h1;  default: s = 4'h2;
        endcase
        return s;
    endfunction

    function automatic logic [79:0] sched(input logic [79:0] x, input int n);
        logic [79:0] y;
        logic [4:0]  c;
        c       = 5'(n);
        y       = {x[18:0], x[79:19]};
        y[79:76] = sb(y[79:76]);
        y[19:15] = y[19:15] ^ c;
        return y;
    endfunction

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [79:0] k,
                        input logic rdy, input logic rs,
                        input logic [63:0] erk, input int eidx,
                        input logic ev, input logic eb, input logic ed);
        vec_t v;
        v.st   = st;
        v.k    = k;
        v.rdy  = rdy;
        v.rs   = rs;
        v.erk  = erk;
        v.eidx = 6'(eidx);
        v.ev   = ev;
        v.eb   = eb;
        v.ed   = ed;
        vq.push_back(v);
    endtask

    localparam logic [79:0] ONES = {80{1'b1}};

    initial begin
        logic [79:0] ks;
        logic [63:0] erk;
        logic [63:0] prv_rk;
        logic [5:0]  prv_idx;
        logic        prv_v;
        logic        rdy;
        int          acc;
        int          done_seen;

        nvec      = 0;
        nerr      = 0;
        rst       = 1'b1;
        start     = 1'b0;
        key       = '0;
        rk_ready  = 1'b0;
        start2    = 1'b0;
        key2      = '0;
        rk_ready2 = 1'b0;

        ks = '0;
        mk0[1] = ks[79:16];
        for (int n = 1; n < 32; n++) begin
            ks = sched(ks, n);
            mk0[n+1] = ks[79:16];
        end
        ks = ONES;
        mk1[1] = ks[79:16];
        for (int n = 1; n < 32; n++) begin
            ks = sched(ks, n);
            mk1[n+1] = ks[79:16];
        end

        // Reset, idle with noise, then a zero-key run with one stall
        // and a start pulse inside EMIT.
        push(0, '0,   0, 1, '0, 0, 0, 0, 0);
        push(0, '0,   1, 0, '0, 0, 0, 0, 0);
        push(0, ONES, 0, 0, '0, 0, 0, 0, 0);
        push(1, '0,   1, 0, 64'h0000000000000000, 1, 1, 1, 0);
        for (int n = 2; n <= 32; n++) begin
            if (n == 6)
                push(0, ONES, 0, 0, mk0[5], 5, 1, 1, 0);
            erk = mk0[n];
            if (n == 2)  erk = 64'hc000000000000000;
            if (n == 32) erk = 64'h6dab31744f41d700;
            push((n == 10), ONES, 1, 0, erk, n, 1, 1, 0);
        end
        push(0, '0,   1, 0, '0, 0, 0, 1, 1);
        push(1, ONES, 1, 0, '0, 0, 0, 0, 0);
        push(1, ONES, 1, 0, 64'hffffffffffffffff, 1, 1, 1, 0);
        for (int n = 2; n <= 32; n++) begin
            erk = mk1[n];
            if (n == 2) erk = 64'h2fffffffffffffff;
            push(0, '0, 1, 0, erk, n, 1, 1, 0);
        end
        push(0, '0, 1, 0, '0, 0, 0, 1, 1);
        push(0, '0, 0, 0, '0, 0, 0, 0, 0);

        foreach (vq[j]) begin
            start    = vq[j].st;
            key      = vq[j].k;
            rk_ready = vq[j].rdy;
            rst      = vq[j].rs;
            step();
            chk($sformatf("vec%0d", j),
                80'({rk, rk_idx, rk_valid, busy, done}),
                80'({vq[j].erk, vq[j].eidx, vq[j].ev, vq[j].eb, vq[j].ed}));
        end
        start = 1'b0;

        // Random backpressure on a zero-key run.
        key      = '0;
        rk_ready = 1'b0;
        start    = 1'b1;
        step();
        start     = 1'b0;
        acc       = 0;
        done_seen = 0;
        for (int c = 0; c < 400 && done_seen == 0; c++) begin
            rdy      = 1'($urandom_range(0, 1));
            rk_ready = rdy;
            prv_rk   = rk;
            prv_idx  = rk_idx;
            prv_v    = rk_valid;
            step();
            if (prv_v && rdy) begin
                acc++;
                chk("bp_order", 80'(prv_idx), 80'(acc));
                if (prv_idx >= 1 && prv_idx <= 32)
                    chk("bp_key", 80'(prv_rk), 80'(mk0[prv_idx]));
            end else if (prv_v) begin
                chk("bp_hold", 80'({rk, rk_idx}), 80'({prv_rk, prv_idx}));
            end
            if (done) done_seen = 1;
        end
        chk("bp_done_seen", 80'(done_seen), 80'(1));
        chk("bp_accepts", 80'(acc), 80'(32));
        rk_ready = 1'b0;
        step();
        chk("bp_idle", 80'({rk_valid, busy, done}), 80'(0));

        // Reset in the middle of a run.
        rk_ready = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && rk_idx != 6'd17; c++) step();
        chk("rst_at17", 80'(rk_idx), 80'(17));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_outs", 80'({rk, rk_idx, rk_valid, busy, done}), 80'(0));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_nodone", 80'({rk_valid, busy, done}), 80'(0));
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_restart", 80'({rk, rk_idx, rk_valid}), 80'({mk0[1], 6'd1, 1'b1}));
        step();
        chk("rst_k2", 80'({rk, rk_idx}), 80'({mk0[2], 6'd2}));

        // ROUNDS=2 instance emits exactly two keys.
        key2      = ONES;
        rk_ready2 = 1'b1;
        start2    = 1'b1;
        step();
        start2 = 1'b0;
        key2   = '0;
        chk("r2_k1", 80'({rk2, rk_idx2, rk_valid2, busy2, done2}),
            80'({64'hffffffffffffffff, 6'd1, 1'b1, 1'b1, 1'b0}));
        step();
        chk("r2_k2", 80'({rk2, rk_idx2, rk_valid2, busy2, done2}),
            80'({64'h2fffffffffffffff, 6'd2, 1'b1, 1'b1, 1'b0}));
        step();
        chk("r2_done", 80'({rk2, rk_idx2, rk_valid2, busy2, done2}),
            80'({64'h0, 6'd0, 1'b0, 1'b1, 1'b1}));
        step();
        chk("r2_idle", 80'({rk2, rk_idx2, rk_valid2, busy2, done2}), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
